// File: rtl/sum_serial_pkg.sv
// Shared state encoding for the serial-adder sequencer.
package sum_serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  localparam state_e ST_RESET = IDLE;

endpackage

// File: rtl/sum_serial_seq_fa_cell.sv
// 1-bit full adder with carry flop; clr restarts the carry and en advances it.
// Sum is combinational from a/b and the stored carry; co exposes the carry flop.
module serial_fa_cell (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic a,
  input  logic b,
  output logic s,
  output logic co
);

  logic carry_q;
  logic carry_d;

  assign s  = a ^ b ^ carry_q;
  assign co = carry_q;

  // Carry holds outside RUN so the final carry-out stays readable.
  always_comb begin
    carry_d = carry_q;
    if (clr) begin
      carry_d = 1'b0;
    end else if (en) begin
      carry_d = (a & b) | (carry_q & (a ^ b));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      carry_q <= 1'b0;
    end else begin
      carry_q <= carry_d;
    end
  end

endmodule

// File: rtl/sum_serial_seq.sv
// Feeds two N-bit operands LSB-first through one serial full adder; result valid N cycles
// after accept. Input stalls (in_ready=0) until the result is taken; output holds until out_ready.
module sum_serial_seq
  import sum_serial_pkg::*;
#(
  parameter int N = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_sum,
  output logic         out_cout,
  output logic         busy
);

  localparam int CNT_W = $clog2(N);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N-1:0]       a_sr_q, a_sr_d;
  logic [N-1:0]       b_sr_q, b_sr_d;
  logic [N-1:0]       sum_sr_q, sum_sr_d;
  logic               in_ready_q;
  logic               out_valid_q;
  logic               busy_q;
  logic               fa_clr;
  logic               fa_en;
  logic               fa_s;
  logic               fa_co;

  serial_fa_cell u_fa (
    .clk (clk),
    .rst (rst),
    .clr (fa_clr),
    .en  (fa_en),
    .a   (a_sr_q[0]),
    .b   (b_sr_q[0]),
    .s   (fa_s),
    .co  (fa_co)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    sum_sr_d = sum_sr_q;
    fa_clr   = 1'b0;
    fa_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          a_sr_d  = in_a;
          b_sr_d  = in_b;
          cnt_d   = '0;
          fa_clr  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        fa_en    = 1'b1;
        a_sr_d   = {1'b0, a_sr_q[N-1:1]};
        b_sr_d   = {1'b0, b_sr_q[N-1:1]};
        sum_sr_d = {fa_s, sum_sr_q[N-1:1]};
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(N - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs are registered copies of the next state, so in_ready
  // stays low while reset is asserted and no input reaches an output combinationally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_RESET;
      cnt_q       <= '0;
      a_sr_q      <= '0;
      b_sr_q      <= '0;
      sum_sr_q    <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_sr_q      <= a_sr_d;
      b_sr_q      <= b_sr_d;
      sum_sr_q    <= sum_sr_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
      busy_q      <= (state_d == RUN);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_sum   = sum_sr_q;
  assign out_cout  = fa_co;

endmodule
